// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one bus between IF (if_*) and MEM (mem_*) with ready/stall per requester, registered bus_* request, sticky bus_err/illegal_op.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MEM_BURST_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              startin,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err,
  output logic              illegal_op
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY} state_t;
  state_t state_q, state_d;
  logic bus_req_q, bus_req_d, bus_we_q, bus_we_d, bus_err_q, bus_err_d, illegal_q, illegal_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [3:0] streak_q, streak_d;
  logic [7:0] wd_q, wd_d;
  logic busy, timeout, done, mreq, grant_mem;
  assign mreq = mem_read | mem_write;
  assign busy = state_q != IDLE;
  assign timeout = busy & (wd_q == 8'(TIMEOUT - 1));
  assign done = busy & (bus_ack | timeout);
  assign grant_mem = mreq & ~(if_req & (streak_q == 4'(MEM_BURST_MAX)));
  assign if_ready = done & (state_q == IF_BUSY);
  assign mem_ready = done & (state_q == MEM_BUSY);
  assign if_rdata = (if_ready & bus_ack) ? bus_rdata : '0;
  assign mem_rdata = (mem_ready & bus_ack & ~bus_we_q) ? bus_rdata : '0;
  assign stall_if = if_req & ~if_ready;
  assign stall_mem = mreq & ~mem_ready;
  assign bus_req = bus_req_q;
  assign bus_we = bus_we_q;
  assign bus_addr = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_err = bus_err_q;
  assign illegal_op = illegal_q;
  always_comb begin
    state_d = state_q;
    bus_req_d = bus_req_q;
    bus_we_d = bus_we_q;
    bus_addr_d = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    streak_d = streak_q;
    wd_d = wd_q;
    bus_err_d = bus_err_q;
    illegal_d = illegal_q;
    if (state_q == IDLE) begin
      if (grant_mem) begin
        state_d = MEM_BUSY;
        bus_req_d = 1'b1;
        bus_we_d = mem_write;
        bus_addr_d = mem_addr;
        bus_wdata_d = mem_wdata;
        illegal_d = illegal_q | (mem_read & mem_write);
        streak_d = if_req ? ((streak_q == 4'hf) ? streak_q : streak_q + 4'd1) : 4'd0;
      end else if (if_req) begin
        state_d = IF_BUSY;
        bus_req_d = 1'b1;
        bus_we_d = 1'b0;
        bus_addr_d = if_addr;
        bus_wdata_d = '0;
        streak_d = 4'd0;
      end
    end else if (done) begin
      state_d = IDLE;
      bus_req_d = 1'b0;
      wd_d = 8'd0;
      bus_err_d = bus_err_q | ~bus_ack;
    end else begin
      wd_d = wd_q + 8'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (startin) begin
      state_q <= IDLE;
      bus_req_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_addr_q <= '0;
      bus_wdata_q <= '0;
      streak_q <= 4'd0;
      wd_q <= 8'd0;
      bus_err_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bus_req_q <= bus_req_d;
      bus_we_q <= bus_we_d;
      bus_addr_q <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      streak_q <= streak_d;
      wd_q <= wd_d;
      bus_err_q <= bus_err_d;
      illegal_q <= illegal_d;
    end
  end
endmodule
